// File: rtl/pwm_sample_player.sv
// Plays a stream of FIFO samples as PWM duty cycles, one sample per symbol of
// STEPS_PER_SAMPLE steps, prefetching the next sample into a shadow register.
module pwm_sample_player #(
  parameter int DATA_WIDTH       = 8,
  parameter int CLKS_PER_STEP    = 1,
  parameter int STEPS_PER_SAMPLE = 255,
  parameter int UNDERRUN_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  empty,
  output logic                  read,
  output logic                  pwm,
  output logic                  tc_pwm_step,
  output logic                  tc_pwm_symb,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam int PW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(CLKS_PER_STEP - 1);
  localparam logic [DATA_WIDTH-1:0] STEP_LAST  = DATA_WIDTH'(STEPS_PER_SAMPLE - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_FETCH,
    S_LATCH
  } fetch_state_t;

  fetch_state_t            r_state;
  fetch_state_t            w_state_next;
  logic [PW-1:0]           r_presc;
  logic [DATA_WIDTH-1:0]   r_step;
  logic [DATA_WIDTH-1:0]   r_duty;
  logic [DATA_WIDTH-1:0]   r_shadow;
  logic                    r_shadow_valid;
  logic                    r_started;
  logic                    r_pwm;
  logic [15:0]             r_underrun_count;
  logic                    w_tc_step;
  logic                    w_tc_symb;
  logic                    w_underrun;

  // Terminal counts are qualified by rst so they stay low during reset even
  // when the prescaler's reset value already equals its last count.
  assign w_tc_step  = rst && enable && (r_presc == PRESC_LAST);
  assign w_tc_symb  = w_tc_step && (r_step == STEP_LAST);
  assign w_underrun = w_tc_symb && !r_shadow_valid && r_started;

  assign pwm            = r_pwm;
  assign tc_pwm_step    = w_tc_step;
  assign tc_pwm_symb    = w_tc_symb;
  assign underrun       = w_underrun;
  assign underrun_count = r_underrun_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    read         = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (!r_shadow_valid && !empty && enable) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        read         = 1'b1;
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        w_state_next = S_WAIT;
      end
      default: begin
        w_state_next = S_WAIT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc          <= '0;
      r_step           <= '0;
      r_duty           <= '0;
      // NOTE: the shadow data register is reset too, not just its valid flag,
      // so no stale word from before reset can ever become a duty.
      r_shadow         <= '0;
      r_shadow_valid   <= 1'b0;
      r_started        <= 1'b0;
      r_pwm            <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_pwm <= enable && (r_step < r_duty);

      if (enable) begin
        r_presc <= w_tc_step ? '0 : r_presc + 1'b1;
      end

      if (w_tc_step) begin
        r_step <= w_tc_symb ? '0 : r_step + 1'b1;
      end

      // FIFO data is valid the cycle after the read strobe.
      if (r_state == S_LATCH) begin
        r_shadow       <= sample;
        r_shadow_valid <= 1'b1;
      end

      if (w_tc_symb) begin
        if (r_shadow_valid) begin
          r_duty         <= r_shadow;
          r_shadow_valid <= 1'b0;
          r_started      <= 1'b1;
        end else if (r_started) begin
          if (r_underrun_count != 16'hFFFF) begin
            r_underrun_count <= r_underrun_count + 16'd1;
          end
          if (UNDERRUN_MODE == 1) begin
            r_duty <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_sample_player.sv
// Scoreboard bench for pwm_sample_player: two builds (prescaled/hold and
// unprescaled/force-zero) driven from bench FIFOs and checked against a model.
`timescale 1ns/1ps
module tb_pwm_sample_player;

  localparam int NI = 2;
  localparam int FD = 4096;

  function automatic int cps(input int k);   return (k == 0) ? 4  : 1;   endfunction
  function automatic int sps(input int k);   return (k == 0) ? 15 : 12;  endfunction
  function automatic int umode(input int k); return (k == 0) ? 0  : 1;   endfunction
  function automatic int dmask(input int k); return (k == 0) ? 255 : 15; endfunction

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  // Pushed words live in fmem; the bench FIFO (rd) and the model (mrd) read
  // them independently.
  int unsigned fmem [NI][FD];
  int          wr   [NI];
  int          rd   [NI];

  logic [7:0]  sample0 = '0;
  logic [3:0]  sample1 = '0;
  logic        empty0, empty1;
  logic        read0, pwm0, tcs0, tcy0, und0;
  logic        read1, pwm1, tcs1, tcy1, und1;
  logic [15:0] cnt0, cnt1;

  assign empty0 = (wr[0] == rd[0]);
  assign empty1 = (wr[1] == rd[1]);

  pwm_sample_player #(.DATA_WIDTH(8), .CLKS_PER_STEP(4), .STEPS_PER_SAMPLE(15),
                      .UNDERRUN_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample0), .empty(empty0),
    .read(read0), .pwm(pwm0), .tc_pwm_step(tcs0), .tc_pwm_symb(tcy0),
    .underrun(und0), .underrun_count(cnt0));

  pwm_sample_player #(.DATA_WIDTH(4), .CLKS_PER_STEP(1), .STEPS_PER_SAMPLE(12),
                      .UNDERRUN_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample1), .empty(empty1),
    .read(read1), .pwm(pwm1), .tc_pwm_step(tcs1), .tc_pwm_symb(tcy1),
    .underrun(und1), .underrun_count(cnt1));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  function automatic logic [31:0] pack(input logic r, input logic p, input logic ts,
                                       input logic ty, input logic u, input logic [15:0] c);
    return {11'b0, r, p, ts, ty, u, c};
  endfunction

  // Reference model state: what the player should hold at the start of a cycle.
  typedef struct {
    int presc;
    int step;
    int duty;
    int sh;
    bit shv;
    bit started;
    int cnt;
    int fetch_age;  // 0 idle, 1 read issued this cycle, 2 data arriving this cycle
    bit pwm_q;
    int pending;
    int mrd;
  } model_t;

  typedef struct {
    bit rd;
    bit pwm;
    bit tcs;
    bit tcy;
    bit und;
    int cnt;
  } exp_t;

  model_t m [NI];
  exp_t   exp_q0[$];
  exp_t   exp_q1[$];

  task automatic model_cycle(input int k);
    model_t s;
    exp_t   e;
    bit     tcs, tcy, start_fetch, latch_now;
    int     keep_rd;
    s   = m[k];
    tcs = rst && enable && (s.presc == cps(k) - 1);
    tcy = tcs && (s.step == sps(k) - 1);
    e.rd  = (s.fetch_age == 1);
    e.pwm = s.pwm_q;
    e.tcs = tcs;
    e.tcy = tcy;
    e.und = tcy && !s.shv && s.started;
    e.cnt = s.cnt;
    if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);

    // A read pops the FIFO even if reset then discards the word.
    if (e.rd && s.mrd != wr[k]) begin
      s.pending = int'(fmem[k][s.mrd]) & dmask(k);
      s.mrd++;
    end

    if (!rst) begin
      keep_rd = s.mrd;
      s       = '{default: 0};
      s.mrd   = keep_rd;
    end else begin
      start_fetch = (s.fetch_age == 0) && !s.shv && (s.mrd != wr[k]) && enable;
      latch_now   = (s.fetch_age == 2);
      s.pwm_q     = enable && (s.step < s.duty);
      if (tcy) begin
        if (s.shv) begin
          s.duty    = s.sh;
          s.shv     = 1'b0;
          s.started = 1'b1;
        end else if (s.started) begin
          if (s.cnt < 65535) s.cnt++;
          if (umode(k) == 1) s.duty = 0;
        end
      end
      if (tcs)    s.step  = (s.step + 1) % sps(k);
      if (enable) s.presc = (s.presc + 1) % cps(k);
      if (latch_now) begin
        s.sh  = s.pending;
        s.shv = 1'b1;
      end
      if (start_fetch)         s.fetch_age = 1;
      else if (s.fetch_age > 0) s.fetch_age = (s.fetch_age + 1) % 3;
    end
    m[k] = s;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) model_cycle(k);
  end

  // Monitor: one expected record per cycle per build.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    check("A scoreboard depth", exp_q0.size(), 1);
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("A {rd,pwm,tcs,tcy,und,cnt}", pack(read0, pwm0, tcs0, tcy0, und0, cnt0),
            pack(e.rd, e.pwm, e.tcs, e.tcy, e.und, 16'(e.cnt)));
    end
    check("B scoreboard depth", exp_q1.size(), 1);
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("B {rd,pwm,tcs,tcy,und,cnt}", pack(read1, pwm1, tcs1, tcy1, und1, cnt1),
            pack(e.rd, e.pwm, e.tcs, e.tcy, e.und, 16'(e.cnt)));
    end
  end

  // Bench FIFOs: pop on read, data valid the following cycle.
  always @(posedge clk) begin : fifo_a
    logic r, em;
    r  = read0;
    em = empty0;
    check("A read while empty", {31'b0, r & em}, 32'd0);
    #1;
    if (r && rd[0] != wr[0]) begin
      sample0 = 8'(fmem[0][rd[0]]);
      rd[0]++;
    end
  end

  always @(posedge clk) begin : fifo_b
    logic r, em;
    r  = read1;
    em = empty1;
    check("B read while empty", {31'b0, r & em}, 32'd0);
    #1;
    if (r && rd[1] != wr[1]) begin
      sample1 = 4'(fmem[1][rd[1]]);
      rd[1]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int k, input int unsigned v);
    if (wr[k] < FD) begin
      fmem[k][wr[k]] = v;
      wr[k]++;
    end
  endtask

  initial begin : stimulus
    bit seen;
    for (int k = 0; k < NI; k++) begin
      wr[k] = 0;
      rd[k] = 0;
      m[k]  = '{default: 0};
    end
    tick(3);

    // Two ordinary samples, played back to back.
    push(0, 100); push(0, 200);
    push(1, 5);   push(1, 12);
    rst    = 1'b1;
    enable = 1'b1;
    tick(4 * 60);

    // Duty extremes: constant low, then constant high.
    push(0, 0); push(0, 255);
    push(1, 0); push(1, 15);
    tick(4 * 60);

    // FIFO left empty: consecutive underruns.
    tick(5 * 60);

    // Pause mid-symbol, then resume.
    push(0, 77); push(1, 9);
    tick(90);
    enable = 1'b0;
    tick(10);
    enable = 1'b1;
    tick(3 * 60);

    // Randomised traffic and pauses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4 && (wr[0] - rd[0]) < 8) push(0, $urandom_range(0, 255));
      if ($urandom_range(0, 99) < 10 && (wr[1] - rd[1]) < 8) push(1, $urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      tick(1);
    end
    enable = 1'b1;

    // Reset landing on a FETCH cycle of build A.
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (wr[0] == rd[0]) push(0, $urandom_range(1, 254));
      tick(1);
      if (read0) begin
        seen = 1'b1;
        break;
      end
    end
    check("A fetch seen before reset", {31'b0, seen}, 32'd1);
    rst = 1'b0;
    tick(1);
    check("A outputs after reset in FETCH", pack(read0, pwm0, tcs0, tcy0, und0, cnt0), 32'd0);
    rst = 1'b1;
    tick(200);
    push(0, 50); push(1, 3);
    tick(300);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
